// File: rtl/conv_lane_scheduler.sv
// Control sequencer for the P-lane convolution datapath: issues x/filter reads,
// steers the MAC accumulators and strobes one block store per P outputs.
module conv_lane_scheduler #(
  parameter int ADDRX = 6,
  parameter int ADDRF = 6,
  parameter int LENX  = 64,
  parameter int LENF  = 33,
  parameter int P     = 8,
  localparam int SIZE = LENX - LENF + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               read_done_x,
  input  logic               write_done,
  input  logic               all_done,
  output logic [P*ADDRX-1:0] m_addr_read_x,
  output logic [ADDRF-1:0]   m_addr_read_f,
  output logic               clr_acc,
  output logic               en_acc,
  output logic               valid_op,
  output logic [ADDRX-1:0]   start_addr,
  output logic [P-1:0]       lane_valid,
  output logic               conv_done,
  output logic               busy,
  output logic [2:0]         fsm_state
);

  localparam int NBLK = (SIZE + P - 1) / P;
  localparam int KW   = (LENF > 1) ? $clog2(LENF) : 1;
  localparam int BW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int AW   = ADDRX + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_STORE = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Handshake: read_done_x is a level sampled only in S_IDLE; write_done is
  // sampled only in S_WAIT; all_done is sampled only in S_DONE. valid_op is a
  // single-cycle strobe with no back-pressure.

  state_t         state, state_n;
  logic [KW-1:0]  k, k_n;
  logic [BW-1:0]  blk, blk_n;
  logic [AW-1:0]  base;
  logic [AW-1:0]  lane_sum [P];
  logic [P-1:0]   lane_valid_n;
  logic           addr_act;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      k          <= '0;
      blk        <= '0;
      en_acc     <= 1'b0;
      start_addr <= '0;
      lane_valid <= '0;
    end else begin
      state  <= state_n;
      k      <= k_n;
      blk    <= blk_n;
      // Read data lags the address by one cycle, so accumulation trails issue.
      en_acc <= (state == S_ISSUE);
      if (state == S_DRAIN) begin
        start_addr <= base[ADDRX-1:0];
        lane_valid <= lane_valid_n;
      end
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    blk_n   = blk;
    case (state)
      S_IDLE: begin
        if (read_done_x) begin
          state_n = S_ISSUE;
          k_n     = '0;
          blk_n   = '0;
        end
      end
      S_ISSUE: begin
        if (k == KW'(LENF - 1)) state_n = S_DRAIN;
        else                    k_n     = k + KW'(1);
      end
      S_DRAIN: state_n = S_STORE;
      S_STORE: state_n = S_WAIT;
      S_WAIT: begin
        if (write_done) begin
          if (blk == BW'(NBLK - 1)) begin
            state_n = S_DONE;
          end else begin
            state_n = S_ISSUE;
            blk_n   = blk + BW'(1);
            k_n     = '0;
          end
        end
      end
      S_DONE: begin
        if (all_done) begin
          state_n = S_IDLE;
          blk_n   = '0;
          k_n     = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // One spare bit keeps blk*P+i+k from wrapping before the clamp.
  assign base     = AW'(blk) * AW'(P);
  assign addr_act = (state == S_ISSUE) || (state == S_DRAIN);

  always_comb begin
    m_addr_read_x = '0;
    m_addr_read_f = '0;
    lane_valid_n  = '0;
    for (int i = 0; i < P; i++) begin
      lane_sum[i] = base + AW'(i) + AW'(k);
      if (lane_sum[i] > AW'(LENX - 1)) lane_sum[i] = AW'(LENX - 1);
      if (addr_act) m_addr_read_x[i*ADDRX +: ADDRX] = lane_sum[i][ADDRX-1:0];
      lane_valid_n[i] = ((base + AW'(i)) < AW'(SIZE));
    end
    if (addr_act) m_addr_read_f = ADDRF'(k);
  end

  assign clr_acc   = (state == S_ISSUE) && (k == '0);
  assign valid_op  = (state == S_STORE);
  assign conv_done = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_conv_lane_scheduler.sv
// Bench for conv_lane_scheduler: default 8-lane instance plus a 5-lane instance,
// checked every cycle against a block/offset timeline model and a store scoreboard.
module tb_conv_lane_scheduler;

  localparam int ADDRX = 6;
  localparam int ADDRF = 6;
  localparam int LENX  = 64;
  localparam int LENF  = 33;
  localparam int SIZE  = LENX - LENF + 1;
  localparam int P0    = 8;
  localparam int P1    = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rdx [2] = '{1'b0, 1'b0};
  logic wd  [2] = '{1'b0, 1'b0};
  logic ad  [2] = '{1'b0, 1'b0};

  logic [P0*ADDRX-1:0] ax0;
  logic [ADDRF-1:0]    af0;
  logic                clr0, en0, vop0, cd0, busy0;
  logic [ADDRX-1:0]    sa0;
  logic [P0-1:0]       lv0;
  logic [2:0]          st0;

  logic [P1*ADDRX-1:0] ax1;
  logic [ADDRF-1:0]    af1;
  logic                clr1, en1, vop1, cd1, busy1;
  logic [ADDRX-1:0]    sa1;
  logic [P1-1:0]       lv1;
  logic [2:0]          st1;

  conv_lane_scheduler #(.ADDRX(ADDRX), .ADDRF(ADDRF), .LENX(LENX), .LENF(LENF), .P(P0)) dut0 (
    .clk(clk), .reset(rst_n), .read_done_x(rdx[0]), .write_done(wd[0]), .all_done(ad[0]),
    .m_addr_read_x(ax0), .m_addr_read_f(af0), .clr_acc(clr0), .en_acc(en0), .valid_op(vop0),
    .start_addr(sa0), .lane_valid(lv0), .conv_done(cd0), .busy(busy0), .fsm_state(st0)
  );

  conv_lane_scheduler #(.ADDRX(ADDRX), .ADDRF(ADDRF), .LENX(LENX), .LENF(LENF), .P(P1)) dut1 (
    .clk(clk), .reset(rst_n), .read_done_x(rdx[1]), .write_done(wd[1]), .all_done(ad[1]),
    .m_addr_read_x(ax1), .m_addr_read_f(af1), .clr_acc(clr1), .en_acc(en1), .valid_op(vop1),
    .start_addr(sa1), .lane_valid(lv1), .conv_done(cd1), .busy(busy1), .fsm_state(st1)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each run is a sequence of blocks; a block is described by its offset t in
  // cycles: t<LENF reads tap t, t==LENF is the final product, t==LENF+1 stores,
  // t>=LENF+2 waits for write_done. m_st: 0 idle, 1 running, 2 done.
  int pp [2] = '{P0, P1};
  int nb [2] = '{(SIZE + P0 - 1) / P0, (SIZE + P1 - 1) / P1};
  int m_st  [2] = '{0, 0};
  int m_blk [2] = '{0, 0};
  int m_t   [2] = '{0, 0};
  logic [63:0] m_sa [2] = '{64'd0, 64'd0};
  logic [63:0] m_lv [2] = '{64'd0, 64'd0};
  logic [63:0] exp_q0 [$];
  logic [63:0] exp_q1 [$];

  function automatic logic [63:0] lv_of(input int d, input int b);
    logic [63:0] r = 64'd0;
    for (int i = 0; i < pp[d]; i++)
      if (b * pp[d] + i < SIZE) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] exp_ax(input int d);
    logic [63:0] r = 64'd0;
    int kk, a;
    if (m_st[d] == 1 && m_t[d] <= LENF) begin
      kk = (m_t[d] < LENF) ? m_t[d] : LENF - 1;
      for (int i = 0; i < pp[d]; i++) begin
        a = m_blk[d] * pp[d] + i + kk;
        if (a > LENX - 1) a = LENX - 1;
        r = r | (64'(a) << (i * ADDRX));
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_af(input int d);
    if (m_st[d] == 1 && m_t[d] <= LENF) return 64'((m_t[d] < LENF) ? m_t[d] : LENF - 1);
    return 64'd0;
  endfunction

  function automatic logic [4:0] exp_ctl(input int d);
    logic run;
    run = (m_st[d] == 1);
    return {run && m_t[d] == 0,
            run && m_t[d] >= 1 && m_t[d] <= LENF,
            run && m_t[d] == LENF + 1,
            m_st[d] == 2,
            m_st[d] != 0};
  endfunction

  task automatic step(input int d);
    logic [63:0] e;
    case (m_st[d])
      0: if (rdx[d]) begin m_st[d] = 1; m_blk[d] = 0; m_t[d] = 0; end
      1: begin
        if (m_t[d] <= LENF + 1) begin
          m_t[d]++;
          if (m_t[d] == LENF + 1) begin
            m_sa[d] = 64'(m_blk[d] * pp[d]);
            m_lv[d] = lv_of(d, m_blk[d]);
            e = (m_lv[d] << 8) | m_sa[d];
            if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
          end
        end else if (wd[d]) begin
          if (m_blk[d] == nb[d] - 1) m_st[d] = 2;
          else begin m_blk[d]++; m_t[d] = 0; end
        end
      end
      default: if (ad[d]) begin m_st[d] = 0; m_blk[d] = 0; end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_st[d] = 0; m_blk[d] = 0; m_t[d] = 0; m_sa[d] = 64'd0; m_lv[d] = 64'd0;
      end else begin
        step(d);
      end
    end
  end

  task automatic check_dut(input int d, input logic [63:0] ax, input logic [63:0] af,
                           input logic [4:0] ctl, input logic [63:0] sa, input logic [63:0] lv);
    check($sformatf("d%0d_addr_x", d), ax, exp_ax(d));
    check($sformatf("d%0d_addr_f", d), af, exp_af(d));
    check($sformatf("d%0d_ctl", d), 64'(ctl), 64'(exp_ctl(d)));
    check($sformatf("d%0d_start_addr", d), sa, m_sa[d]);
    check($sformatf("d%0d_lane_valid", d), lv, m_lv[d]);
  endtask

  // Per-cycle comparison plus store scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic [63:0] e;
    check_dut(0, 64'(ax0), 64'(af0), {clr0, en0, vop0, cd0, busy0}, 64'(sa0), 64'(lv0));
    check_dut(1, 64'(ax1), 64'(af1), {clr1, en1, vop1, cd1, busy1}, 64'(sa1), 64'(lv1));
    if (vop0) begin
      if (exp_q0.size() == 0) check("d0_store_unexpected", 64'd1, 64'd0);
      else begin e = exp_q0.pop_front(); check("d0_store", (64'(lv0) << 8) | 64'(sa0), e); end
    end
    if (vop1) begin
      if (exp_q1.size() == 0) check("d1_store_unexpected", 64'd1, 64'd0);
      else begin e = exp_q1.pop_front(); check("d1_store", (64'(lv1) << 8) | 64'(sa1), e); end
    end
  end

  // ---------------- directed + random stimulus ----------------
  int t0, first_clr, first_en, en_cnt, done_cyc, n5;
  int st_cyc [$];
  int st_sa [$];
  logic [63:0] last_sa, last_lv, exp_a;
  logic found, sweep_seen;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Default run: read_done_x at cycle 0, write_done tied high.
    wd[0] = 1'b1; rdx[0] = 1'b1; t0 = cyc;
    first_clr = -1; first_en = -1; en_cnt = 0; done_cyc = -1; sweep_seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (clr0 && first_clr < 0) first_clr = cyc - t0;
      if (en0) begin
        if (first_en < 0) first_en = cyc - t0;
        if (st_cyc.size() == 0) en_cnt++;
      end
      if (st_cyc.size() == 3 && af0 == 6'd32 && !sweep_seen) begin
        sweep_seen = 1'b1;
        check("sweep_lane7", 64'(ax0[7*ADDRX +: ADDRX]), 64'd63);
        check("sweep_lane0", 64'(ax0[0 +: ADDRX]), 64'd56);
      end
      if (vop0) begin
        st_cyc.push_back(cyc - t0);
        st_sa.push_back(int'(sa0));
        check("store_lv_ff", 64'(lv0), 64'hFF);
      end
      if (cd0) begin done_cyc = cyc - t0; break; end
    end
    check("first_clr_cycle", 64'(first_clr), 64'd1);
    check("first_en_cycle", 64'(first_en), 64'd2);
    check("en_cycles_blk0", 64'(en_cnt), 64'(LENF));
    check("sweep_reached", 64'(sweep_seen), 64'd1);
    check("store_count", 64'(st_cyc.size()), 64'd4);
    for (int j = 0; j < st_cyc.size() && j < 4; j++) begin
      check($sformatf("store%0d_cycle", j), 64'(st_cyc[j]), 64'(35 + 36 * j));
      check($sformatf("store%0d_sa", j), 64'(st_sa[j]), 64'(8 * j));
    end
    check("done_cycle", 64'(done_cyc), 64'd145);

    // DONE with read_done_x still high: one IDLE cycle, then a fresh run.
    ad[0] = 1'b1;
    @(negedge clk);
    ad[0] = 1'b0;
    check("idle_after_done", {63'd0, busy0 | cd0}, 64'd0);
    @(negedge clk);
    check("restart_clr", 64'(clr0), 64'd1);
    rdx[0] = 1'b0;

    // Hold write_done low for 10 cycles after the block 0 store.
    wd[0] = 1'b0;
    for (int n = 0; n < 100 && !vop0; n++) @(negedge clk);
    check("blk0_store_seen", 64'(vop0), 64'd1);
    repeat (10) begin
      @(negedge clk);
      check("wait_hold_sa", 64'(sa0), 64'd0);
      check("wait_no_issue", {62'd0, clr0, en0}, 64'd0);
    end
    wd[0] = 1'b1;
    @(negedge clk);
    wd[0] = 1'b0;
    check("blk1_clr_after_wd", 64'(clr0), 64'd1);
    repeat (5) @(negedge clk);
    wd[0] = 1'b1;
    @(negedge clk);
    wd[0] = 1'b0;
    for (int n = 0; n < 100 && !vop0; n++) @(negedge clk);
    check("blk1_store_sa", 64'(sa0), 64'd8);
    repeat (5) begin
      @(negedge clk);
      check("pulse_ignored", {62'd0, clr0, en0}, 64'd0);
    end

    // Asynchronous reset during block 2, tap 10.
    wd[0] = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (m_st[0] == 1 && m_blk[0] == 2 && m_t[0] == 10) begin found = 1'b1; break; end
    end
    check("reach_blk2_k10", 64'(found), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_addr", 64'(ax0), 64'd0);
    check("async_rst_ctl", 64'({af0, clr0, en0, vop0, sa0, lv0, cd0, busy0}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rdx[0] = 1'b1;
    @(negedge clk);
    rdx[0] = 1'b0;
    exp_a = 64'd0;
    for (int i = 0; i < P0; i++) exp_a = exp_a | (64'(i) << (i * ADDRX));
    check("rst_restart_clr", 64'(clr0), 64'd1);
    check("rst_restart_addr", 64'(ax0), exp_a);
    for (int n = 0; n < 200 && !cd0; n++) @(negedge clk);
    check("rst_run_done", 64'(cd0), 64'd1);
    ad[0] = 1'b1;
    @(negedge clk);
    ad[0] = 1'b0;

    // Five-lane instance: 7 blocks, last one partial with clamped lanes.
    wd[1] = 1'b1; rdx[1] = 1'b1; n5 = 0; last_sa = 64'd0; last_lv = 64'd0;
    sweep_seen = 1'b0;
    for (int n = 0; n < 400 && !cd1; n++) begin
      @(negedge clk);
      rdx[1] = 1'b0;
      if (busy1 && n5 == 6 && af1 == 6'd32 && !sweep_seen) begin
        sweep_seen = 1'b1;
        check("p5_lane0_addr", 64'(ax1[0 +: ADDRX]), 64'd62);
        for (int i = 2; i < P1; i++)
          check($sformatf("p5_lane%0d_clamp", i), 64'(ax1[i*ADDRX +: ADDRX]), 64'd63);
      end
      if (vop1) begin n5++; last_sa = 64'(sa1); last_lv = 64'(lv1); end
    end
    check("p5_store_count", 64'(n5), 64'd7);
    check("p5_last_sa", last_sa, 64'd30);
    check("p5_last_lv", last_lv, 64'b00011);
    check("p5_clamp_seen", 64'(sweep_seen), 64'd1);
    ad[1] = 1'b1;
    @(negedge clk);
    ad[1] = 1'b0;

    // Random handshake traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        rdx[d] = ($urandom_range(0, 3) == 0);
        wd[d]  = ($urandom_range(0, 2) == 0);
        ad[d]  = ($urandom_range(0, 3) == 0);
      end
    end
    @(negedge clk);
    check("sb0_empty", 64'(exp_q0.size()), 64'd0);
    check("sb1_empty", 64'(exp_q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
